// File: rtl/cloud_layer.sv
// Background cloud renderer: NUM_CLOUDS scrolling sprite channels sharing one
// 1-bpp bitmap, with a registered per-pixel cloud mask for the colour mux.
module cloud_layer #(
   parameter int NUM_CLOUDS = 3,
   parameter int SCREEN_W   = 800,
   parameter int SPR_W      = 100,
   parameter int SPR_H      = 18,
   parameter int BASE_H     = 100,
   parameter int HSTEP      = 4,
   parameter int WAIT_MIN   = 16,
   parameter int WAIT_STEP  = 8
) (
   input  logic                  lcd_pclk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  clear,
   input  logic                  is_living,
   input  logic [3:0]            move_rate,
   input  logic [4:0]            random_five,
   input  logic [10:0]           pixel_xpos,
   input  logic [10:0]           pixel_ypos,
   output logic                  cloud_draw,
   output logic [NUM_CLOUDS-1:0] active_mask
);

   localparam int OFF_W = $clog2(SCREEN_W + SPR_W + 16);
   localparam int WC_W  = $clog2(WAIT_MIN + 31 * WAIT_STEP + 1);
   localparam int H_W   = $clog2(31 * HSTEP + 1);
   localparam int CW    = 16;
   localparam int ROM_N = SPR_W * SPR_H;
   localparam int IDX_W = $clog2(ROM_N);

   localparam logic [OFF_W-1:0]     OFF_END = OFF_W'(SCREEN_W + SPR_W);
   localparam logic [10:0]          X_END   = 11'(SCREEN_W);
   localparam logic signed [CW-1:0] TOP0    = CW'(BASE_H - SPR_H + 1);
   localparam logic signed [CW-1:0] SW_S    = CW'(SCREEN_W);
   localparam logic signed [CW-1:0] SPW_S   = CW'(SPR_W);
   localparam logic signed [CW-1:0] SPH_S   = CW'(SPR_H);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SCROLL
   } state_e;

   state_e                st_q  [NUM_CLOUDS];
   logic [OFF_W-1:0]      off_q [NUM_CLOUDS];
   logic [WC_W-1:0]       wc_q  [NUM_CLOUDS];
   logic [H_W-1:0]        hgt_q [NUM_CLOUDS];
   logic [NUM_CLOUDS-1:0] acc_q;

   logic [4:0]            sum_d [NUM_CLOUDS];
   logic [OFF_W-1:0]      off_d [NUM_CLOUDS];
   logic signed [CW-1:0]  dx    [NUM_CLOUDS];
   logic signed [CW-1:0]  dy    [NUM_CLOUDS];
   logic [IDX_W-1:0]      idx   [NUM_CLOUDS];
   logic [NUM_CLOUDS-1:0] spawn_oh;
   logic [NUM_CLOUDS-1:0] hit;
   logic [WC_W-1:0]       spawn_wc;
   logic [H_W-1:0]        spawn_h;
   logic [ROM_N-1:0]      rom_flat;
   logic                  upd;

   // Asymmetric puffy outline (left edge tapers faster) with a stippled texture.
   function automatic logic rom_bit(input int r, input int c);
      int mid;
      int lo;
      int hi;
      mid = SPR_H / 2;
      lo  = (r < mid) ? (mid - r) * 5 : 0;
      hi  = (r < mid) ? SPR_W - 1 - (mid - r) * 3 : SPR_W - 1;
      return (c >= lo) && (c <= hi) && (((c + 2 * r) % 11) != 0);
   endfunction

   for (genvar r = 0; r < SPR_H; r++) begin : g_row
      for (genvar c = 0; c < SPR_W; c++) begin : g_col
         assign rom_flat[r*SPR_W+c] = rom_bit(r, c);
      end
   end

   assign upd      = frame_tick & is_living;
   assign spawn_wc = WC_W'(WAIT_MIN) + WC_W'(random_five) * WC_W'(WAIT_STEP);
   assign spawn_h  = H_W'({random_five[0], random_five[1], random_five[2],
                           random_five[3], random_five[4]}) * H_W'(HSTEP);

   always_comb begin
      spawn_oh = '0;
      for (int i = 0; i < NUM_CLOUDS; i++) begin
         if (st_q[i] == IDLE && spawn_oh == '0) spawn_oh[i] = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CLOUDS; i++) begin
         sum_d[i] = 5'(acc_q[i]) + 5'(move_rate);
         off_d[i] = off_q[i] + OFF_W'(sum_d[i][4:1]);
         dx[i]    = $signed(CW'(pixel_xpos)) + $signed(CW'(off_q[i])) - SW_S;
         dy[i]    = $signed(CW'(pixel_ypos)) - TOP0 - $signed(CW'(hgt_q[i]));
         idx[i]   = IDX_W'(dy[i] * SPW_S + dx[i]);
         hit[i]   = (st_q[i] == SCROLL) && (pixel_xpos < X_END)
                    && !dx[i][CW-1] && (dx[i] < SPW_S)
                    && !dy[i][CW-1] && (dy[i] < SPH_S)
                    && rom_flat[idx[i]];
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLOUDS; i++) begin
            st_q[i]  <= IDLE;
            off_q[i] <= '0;
            wc_q[i]  <= '0;
            hgt_q[i] <= '0;
         end
         acc_q       <= '0;
         active_mask <= '0;
         cloud_draw  <= 1'b0;
      end else begin
         cloud_draw <= ~clear & (|hit);
         if (clear) begin
            for (int i = 0; i < NUM_CLOUDS; i++) begin
               st_q[i]  <= IDLE;
               off_q[i] <= '0;
               wc_q[i]  <= '0;
               hgt_q[i] <= '0;
            end
            acc_q       <= '0;
            active_mask <= '0;
         end else if (upd) begin
            for (int i = 0; i < NUM_CLOUDS; i++) begin
               unique case (st_q[i])
                  IDLE: begin
                     if (spawn_oh[i]) begin
                        st_q[i]  <= WAIT;
                        wc_q[i]  <= spawn_wc;
                        hgt_q[i] <= spawn_h;
                     end
                  end
                  WAIT: begin
                     if (wc_q[i] == '0) begin
                        st_q[i]        <= SCROLL;
                        off_q[i]       <= '0;
                        acc_q[i]       <= 1'b0;
                        active_mask[i] <= 1'b1;
                     end else begin
                        wc_q[i] <= wc_q[i] - WC_W'(1);
                     end
                  end
                  SCROLL: begin
                     if (off_d[i] >= OFF_END) begin
                        st_q[i]        <= IDLE;
                        off_q[i]       <= '0;
                        acc_q[i]       <= 1'b0;
                        active_mask[i] <= 1'b0;
                     end else begin
                        off_q[i] <= off_d[i];
                        acc_q[i] <= sum_d[i][0];
                     end
                  end
                  default: begin
                     st_q[i]        <= IDLE;
                     active_mask[i] <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule
